audio_phrase_seq: RTL
=====================

// Module: audio_phrase_seq
// PURPOSE
//  Queues spoken-clip IDs (digits, operators, words) from the calculator core and plays them back-to-back.
//  Per clip: looks up byte start/end addresses in a writable clip table, starts the audio playback controller, waits for its finish.
//  Sits between calculator logic (push side) and audio_ctrl (start_address/end_address/start/finish).
//  Inserts a fixed silence gap between clips.
// PARAMETERS
//  DEPTH        8     clip-ID FIFO entries (power of 2)
//  NUM_CLIPS    16    clip-table entries; IDW = $clog2(NUM_CLIPS)
//  GAP_CYCLES   2500  idle clk cycles between clips (50 us @ 50 MHz); 0 = no gap
//  ACK_TIMEOUT  64    max cycles waiting for playback to leave idle (SEQ_TIMEOUT_EN only)
// PORTS
//  clk            in   1    50 MHz clock
//  reset_n        in   1    async active-low reset
//  push           in   1    enqueue push_id this cycle
//  push_id        in   IDW  clip index
//  full           out  1    FIFO full
//  count          out  $clog2(DEPTH)+1  FIFO occupancy
//  flush          in   1    empty FIFO; current clip finishes
//  tbl_we         in   1    write clip-table entry
//  tbl_idx        in   IDW  table entry index
//  tbl_start      in   24   clip first byte address
//  tbl_end        in   24   clip last byte address (inclusive)
//  start_address  out  24   to playback ctrl; stable from LOAD until next LOAD
//  end_address    out  24   to playback ctrl; same timing
//  play_start     out  1    one-cycle start pulse to playback ctrl
//  play_finish    in   1    playback ctrl idle flag (high = idle)
//  busy           out  1    high in any state but IDLE
//  err            out  1    sticky: overflow, bad entry or timeout; cleared by flush or reset
// BEHAVIOUR
//  Reset (async, reset_n=0): FIFO empty, count=0, full=0, state IDLE, start/end_address=0, play_start=0, busy=0, err=0.
//   Clip table reset to all zeros.
//  FIFO: push accepted if !full, or if a pop occurs the same cycle.
//   Push while full and no pop: dropped, err<=1.
//   flush beats push in the same cycle; err cleared.
//  Table: synchronous write on tbl_we; a write to the entry being loaded that cycle takes effect next clip.
//  FSM:
//   IDLE:     count!=0 -> LOAD
//   LOAD:     pop head, latch table[id] into start/end_address.
//             If end<start, set err and go to IDLE (clip skipped); else go to START.
//   START:    play_start=1 for exactly 1 cycle -> WAIT_ACK
//   WAIT_ACK: wait for play_finish=0 (the controller edge-traps start, so several cycles of latency) -> WAIT_DONE
//   WAIT_DONE: play_finish=1 -> GAP, gap counter loaded with GAP_CYCLES
//   GAP:      decrement each cycle; at 0, go to LOAD if count!=0, else IDLE.
//             With GAP_CYCLES=0, GAP lasts 1 cycle.
//  Latency: push into an empty idle block -> play_start high 3 cycles later (IDLE, LOAD, START).
//  flush in WAIT_ACK/WAIT_DONE/GAP: FIFO emptied, current clip plays to completion, then IDLE.
//  play_finish is ignored outside WAIT_ACK/WAIT_DONE.
//  start_address/end_address hold their last values in IDLE.
//  reset_n low mid-clip: immediate return to reset values; the playback ctrl is reset by the same net.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: a counter runs in WAIT_ACK.
//   If play_finish is still 1 after ACK_TIMEOUT cycles: err<=1, clip abandoned, go to GAP.
//  SEQ_TIMEOUT_EN undefined: WAIT_ACK waits indefinitely; no timeout counter is synthesised.
// TESTING
//  1. Reset; table[3]={0x000100,0x0001FF}; push id 3.
//     -> play_start 3 cycles later, start_address=0x000100, end_address=0x0001FF.
//  2. Model playback: finish low 4 cycles after start, high 512 cycles later; push 1,2,5.
//     -> three starts in order, each separated by >=GAP_CYCLES idle cycles; busy falls after the last gap.
//  3. Push DEPTH+1 IDs while stalled in WAIT_DONE.
//     -> full=1 at 8 entries, 9th dropped, err=1, count=8.
//  4. table[7]={0x200,0x1FF}; push 7 then 3.
//     -> no start for 7, err=1, clip 3 starts normally.
//  5. Flush mid-WAIT_DONE with 4 queued.
//     -> count=0, err=0, current clip finishes, IDLE after gap, no further play_start.
//  6. SEQ_TIMEOUT_EN: hold play_finish=1 after start.
//     -> err=1 after 64 cycles in WAIT_ACK, next queued clip starts after the gap.

Source files
------------

// File: rtl/audio_phrase_seq_if.sv
// Push-side, clip-table and playback-controller signals of the phrase sequencer.
// master = calculator core / playback controller side, slave = audio_phrase_seq.
interface audio_phrase_seq_if #(
  parameter int DEPTH     = 8,
  parameter int NUM_CLIPS = 16
);
  localparam int IDW = $clog2(NUM_CLIPS);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic           push;
  logic [IDW-1:0] push_id;
  logic           full;
  logic [CW-1:0]  count;
  logic           flush;
  logic           tbl_we;
  logic [IDW-1:0] tbl_idx;
  logic [23:0]    tbl_start;
  logic [23:0]    tbl_end;
  logic [23:0]    start_address;
  logic [23:0]    end_address;
  logic           play_start;
  logic           play_finish;
  logic           busy;
  logic           err;

  modport master (
    output push, push_id, flush, tbl_we, tbl_idx, tbl_start, tbl_end, play_finish,
    input  full, count, start_address, end_address, play_start, busy, err
  );

  modport slave (
    input  push, push_id, flush, tbl_we, tbl_idx, tbl_start, tbl_end, play_finish,
    output full, count, start_address, end_address, play_start, busy, err
  );
endinterface

// File: rtl/audio_phrase_seq.sv
// Clip-ID FIFO + clip table + playback sequencer with a fixed silence gap between clips.
// Optional build macro SEQ_TIMEOUT_EN adds a WAIT_ACK timeout of ACK_TIMEOUT cycles.
module audio_phrase_seq #(
  parameter int DEPTH       = 8,
  parameter int NUM_CLIPS   = 16,
  parameter int GAP_CYCLES  = 2500,
  parameter int ACK_TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset_n,
  audio_phrase_seq_if.slave bus
);
  localparam int IDW = $clog2(NUM_CLIPS);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_C   = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] fifo_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q;
  logic [23:0]    tbl_st_q [NUM_CLIPS];
  logic [23:0]    tbl_en_q [NUM_CLIPS];
  logic [23:0]    start_addr_q, start_addr_d;
  logic [23:0]    end_addr_q, end_addr_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           play_start_q, busy_q, err_q;
  logic           pop_s, push_ok_s, overflow_s, bad_clip_s, timeout_s, ack_expired_s;
  logic [IDW-1:0] head_id_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  logic [AW-1:0] ack_cnt_q;

  // Cycles spent in WAIT_ACK for the current clip
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_cnt_q <= '0;
    end else if (state_q == S_WAIT_ACK) begin
      ack_cnt_q <= ack_cnt_q + AW'(1'b1);
    end else begin
      ack_cnt_q <= '0;
    end
  end

  assign ack_expired_s = (state_q == S_WAIT_ACK) && (ack_cnt_q == AW'(ACK_TIMEOUT - 1));
`else
  // No timeout hardware: WAIT_ACK waits for the controller indefinitely.
  assign ack_expired_s = 1'b0 && (ACK_TIMEOUT > 0);
`endif

  // FIFO handshake: a pop happens only in LOAD with data present; flush beats push
  always_comb begin
    head_id_s  = fifo_q[rd_ptr_q];
    pop_s      = (state_q == S_LOAD) && (count_q != '0);
    push_ok_s  = bus.push && !bus.flush && (!full_q || pop_s);
    overflow_s = bus.push && !bus.flush && full_q && !pop_s;
    if (bus.flush) begin
      count_d = '0;
    end else if (push_ok_s && !pop_s) begin
      count_d = count_q + CW'(1'b1);
    end else if (pop_s && !push_ok_s) begin
      count_d = count_q - CW'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    gap_d        = gap_q;
    bad_clip_s   = 1'b0;
    timeout_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
        else               state_d = S_IDLE;
      end
      S_LOAD: begin
        if (!pop_s) begin
          state_d = S_IDLE;
        end else begin
          start_addr_d = tbl_st_q[head_id_s];
          end_addr_d   = tbl_en_q[head_id_s];
          if (tbl_en_q[head_id_s] < tbl_st_q[head_id_s]) begin
            bad_clip_s = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!bus.play_finish) begin
          state_d = S_WAIT_DONE;
        end else if (ack_expired_s) begin
          timeout_s = 1'b1;
          gap_d     = GAP_C;
          state_d   = S_GAP;
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_DONE: begin
        if (bus.play_finish) begin
          gap_d   = GAP_C;
          state_d = S_GAP;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_GAP: begin
        if (gap_q != '0)        gap_d   = gap_q - GW'(1'b1);
        else if (count_q != '0) state_d = S_LOAD;
        else                    state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, addresses, status flags and FIFO pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      start_addr_q <= 24'h000000;
      end_addr_q   <= 24'h000000;
      gap_q        <= '0;
      play_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      full_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      gap_q        <= gap_d;
      play_start_q <= (state_d == S_START);
      busy_q       <= (state_d != S_IDLE);
      count_q      <= count_d;
      full_q       <= (count_d == DEPTH_C);
      if (bus.flush) begin
        err_q <= 1'b0;
      end else if (overflow_s || bad_clip_s || timeout_s) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
      if (bus.flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop_s)     rd_ptr_q <= rd_ptr_q + PW'(1'b1);
        else           rd_ptr_q <= rd_ptr_q;
        if (push_ok_s) wr_ptr_q <= wr_ptr_q + PW'(1'b1);
        else           wr_ptr_q <= wr_ptr_q;
      end
    end
  end

  // FIFO storage; a simultaneous pop reads the old head before it is overwritten
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (push_ok_s) begin
      fifo_q[wr_ptr_q] <= bus.push_id;
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  // Clip table; LOAD reads pre-write contents, so a same-cycle write applies to the next clip
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CLIPS; i++) begin
        tbl_st_q[i] <= 24'h000000;
        tbl_en_q[i] <= 24'h000000;
      end
    end else if (bus.tbl_we) begin
      tbl_st_q[bus.tbl_idx] <= bus.tbl_start;
      tbl_en_q[bus.tbl_idx] <= bus.tbl_end;
    end else begin
      tbl_st_q[bus.tbl_idx] <= tbl_st_q[bus.tbl_idx];
      tbl_en_q[bus.tbl_idx] <= tbl_en_q[bus.tbl_idx];
    end
  end

  assign bus.full          = full_q;
  assign bus.count         = count_q;
  assign bus.start_address = start_addr_q;
  assign bus.end_address   = end_addr_q;
  assign bus.play_start    = play_start_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;
endmodule
